// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram sequencer feeding the 8-bit processor datapath.  A writable
// microcode store holds one microword per micro-address.  The registered
// microinstruction register (MIR) drives the datapath control lines directly.
// The sequencer branches on live datapath status and reports RUN/HALT to the host.
//
// Microword layout (UWORD_WIDTH = 16 + UPC_WIDTH):
//   [11:0]               CTRL   -> CONTROL_BITS (datapath CONTROL_BITS[24:13])
//   [12]                 EIL    -> EIL_BAR
//   [15:13]              COND   0 seq, 1 jump, 2 C8, 3 Z, 4 ZP_BAR, 5 OVF,
//                               6 C4, 7 halt
//   [UWORD_WIDTH-1:16]   TARGET jump destination
//
// Ports:
//   SYSTEM_CLK    in   clock, rising edge
//   SYSTEM_RST    in   asynchronous active-high reset
//   START         in   start pulse, honoured in IDLE/HALT only
//   START_ADDR    in   entry micro-address taken on START
//   STATUS_BITS   in   [0] C4, [1] C8, [2] Z, [3] ZP_BAR, [4] OVERFLOW
//   UCODE_WE      in   microcode write enable
//   UCODE_ADDR    in   microcode write address
//   UCODE_WDATA   in   microcode write data
//   CONTROL_BITS  out  MIR[11:0], registered
//   EIL_BAR       out  MIR[12], registered
//   BUSY          out  high in RUN
//   DONE          out  high in HALT
//   UPC           out  current micro-PC
//
// Host interface semantics: START and UCODE_WE are single-cycle requests with
// no ready return.  They take effect only in IDLE/HALT (BUSY = 0).  START
// wins over UCODE_WE in the same cycle, so that write is dropped.  Both
// are silently ignored while BUSY = 1.  FSM state is fully visible on the
// {DONE, BUSY} pair (00 IDLE, 01 RUN, 10 HALT).
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter  int UPC_WIDTH   = 5,
    localparam int UWORD_WIDTH = 16 + UPC_WIDTH
) (
    input  logic                   SYSTEM_CLK,
    input  logic                   SYSTEM_RST,
    input  logic                   START,
    input  logic [UPC_WIDTH-1:0]   START_ADDR,
    input  logic [4:0]             STATUS_BITS,
    input  logic                   UCODE_WE,
    input  logic [UPC_WIDTH-1:0]   UCODE_ADDR,
    input  logic [UWORD_WIDTH-1:0] UCODE_WDATA,
    output logic [11:0]            CONTROL_BITS,
    output logic                   EIL_BAR,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [UPC_WIDTH-1:0]   UPC
);

    localparam int DEPTH = 2 ** UPC_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [UPC_WIDTH-1:0]   upc, upc_n;
    logic [UWORD_WIDTH-1:0] mir, mir_n;
    logic                   ucode_wr;
    logic                   jump_taken;

    logic [UWORD_WIDTH-1:0] ucode_mem [DEPTH];

    logic [2:0]             mir_cond;
    logic [UPC_WIDTH-1:0]   mir_target;

    assign mir_cond   = mir[15:13];
    assign mir_target = mir[UWORD_WIDTH-1:16];

    // Status bits are only looked at through this mux, so an X on an
    // unselected bit cannot reach the next-PC logic.
    always_comb begin
        jump_taken = 1'b0;
        case (mir_cond)
            3'd1:    jump_taken = 1'b1;
            3'd2:    jump_taken = STATUS_BITS[1];
            3'd3:    jump_taken = STATUS_BITS[2];
            3'd4:    jump_taken = STATUS_BITS[3];
            3'd5:    jump_taken = STATUS_BITS[4];
            3'd6:    jump_taken = STATUS_BITS[0];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n  = state;
        upc_n    = upc;
        mir_n    = mir;
        ucode_wr = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (START) begin
                    upc_n   = START_ADDR;
                    mir_n   = ucode_mem[START_ADDR];
                    state_n = ST_RUN;
                end else begin
                    mir_n    = '0;
                    ucode_wr = UCODE_WE;
                end
            end
            ST_RUN: begin
                if (mir_cond == 3'd7) begin
                    // The halting word's controls were applied this cycle.
                    // Drop to NOP and keep UPC pointing at it.
                    state_n = ST_HALT;
                    mir_n   = '0;
                end else begin
                    upc_n = jump_taken ? mir_target : upc + UPC_WIDTH'(1);
                    mir_n = ucode_mem[upc_n];
                end
            end
            default: begin
                state_n = ST_IDLE;
                upc_n   = '0;
                mir_n   = '0;
            end
        endcase
    end

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
        if (SYSTEM_RST) begin
            state <= ST_IDLE;
            upc   <= '0;
            mir   <= '0;
        end else begin
            state <= state_n;
            upc   <= upc_n;
            mir   <= mir_n;
        end
    end

    // The store has no reset; its contents survive SYSTEM_RST.
    always_ff @(posedge SYSTEM_CLK) begin
        if (ucode_wr) begin
            ucode_mem[UCODE_ADDR] <= UCODE_WDATA;
        end
    end

    assign CONTROL_BITS = mir[11:0];
    assign EIL_BAR      = mir[12];
    assign BUSY         = (state == ST_RUN);
    assign DONE         = (state == ST_HALT);
    assign UPC          = upc;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    localparam int UPC_W = 5;
    localparam int UW    = 16 + UPC_W;

    logic             SYSTEM_CLK;
    logic             SYSTEM_RST;
    logic             START;
    logic [UPC_W-1:0] START_ADDR;
    logic [4:0]       STATUS_BITS;
    logic             UCODE_WE;
    logic [UPC_W-1:0] UCODE_ADDR;
    logic [UW-1:0]    UCODE_WDATA;
    logic [11:0]      CONTROL_BITS;
    logic             EIL_BAR;
    logic             BUSY;
    logic             DONE;
    logic [UPC_W-1:0] UPC;

    int checks   = 0;
    int failures = 0;

    micro_sequencer #(.UPC_WIDTH(UPC_W)) dut (
        .SYSTEM_CLK   (SYSTEM_CLK),
        .SYSTEM_RST   (SYSTEM_RST),
        .START        (START),
        .START_ADDR   (START_ADDR),
        .STATUS_BITS  (STATUS_BITS),
        .UCODE_WE     (UCODE_WE),
        .UCODE_ADDR   (UCODE_ADDR),
        .UCODE_WDATA  (UCODE_WDATA),
        .CONTROL_BITS (CONTROL_BITS),
        .EIL_BAR      (EIL_BAR),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .UPC          (UPC)
    );

    // clock / reset block
    initial SYSTEM_CLK = 1'b0;
    always #5 SYSTEM_CLK = ~SYSTEM_CLK;

    function automatic logic [UW-1:0] uw(input logic [UPC_W-1:0] target,
                                          input logic [2:0] cond,
                                          input logic eil,
                                          input logic [11:0] ctrl);
        return {target, cond, eil, ctrl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge SYSTEM_CLK);
        #1;
    endtask

    task automatic wr(input logic [UPC_W-1:0] addr, input logic [UW-1:0] data);
        UCODE_WE    = 1'b1;
        UCODE_ADDR  = addr;
        UCODE_WDATA = data;
        step();
        UCODE_WE    = 1'b0;
    endtask

    task automatic start_at(input logic [UPC_W-1:0] addr);
        START      = 1'b1;
        START_ADDR = addr;
        step();
        START      = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [11:0] ctrl, input logic eil,
                             input logic busy, input logic done, input logic [UPC_W-1:0] upc);
        check({tag, "_ctrl"}, 32'(CONTROL_BITS), 32'(ctrl));
        check({tag, "_eil"},  32'(EIL_BAR),      32'(eil));
        check({tag, "_busy"}, 32'(BUSY),         32'(busy));
        check({tag, "_done"}, 32'(DONE),         32'(done));
        check({tag, "_upc"},  32'(UPC),          32'(upc));
    endtask

    initial begin
        int conds [6];
        int bits  [6];
        conds = '{1, 3, 2, 4, 5, 6};
        bits  = '{0, 2, 1, 3, 4, 0};

        SYSTEM_RST  = 1'b1;
        START       = 1'b0;
        START_ADDR  = '0;
        STATUS_BITS = '0;
        UCODE_WE    = 1'b0;
        UCODE_ADDR  = '0;
        UCODE_WDATA = '0;
        step();
        step();
        SYSTEM_RST = 1'b0;
        step();
        check_out("reset", 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Straight-line program with START-in-RUN and write-lock probes
        wr(5'd4, uw(5'd0, 3'd0, 1'b1, 12'h123));
        wr(5'd5, uw(5'd0, 3'd0, 1'b0, 12'h456));
        wr(5'd6, uw(5'd0, 3'd7, 1'b0, 12'h789));
        check_out("idle_hold", 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);
        start_at(5'd4);
        check_out("line_w4", 12'h123, 1'b1, 1'b1, 1'b0, 5'd4);
        START      = 1'b1;
        START_ADDR = 5'd20;
        step();
        START      = 1'b0;
        check_out("line_w5", 12'h456, 1'b0, 1'b1, 1'b0, 5'd5);
        UCODE_WE    = 1'b1;
        UCODE_ADDR  = 5'd6;
        UCODE_WDATA = uw(5'd0, 3'd7, 1'b1, 12'hABC);
        step();
        UCODE_WE    = 1'b0;
        check_out("line_w6", 12'h789, 1'b0, 1'b1, 1'b0, 5'd6);
        step();
        check_out("line_halt", 12'h000, 1'b0, 1'b0, 1'b1, 5'd6);
        step();
        check_out("halt_hold", 12'h000, 1'b0, 1'b0, 1'b1, 5'd6);

        // Write during HALT is accepted and executes on the next START
        wr(5'd6, uw(5'd0, 3'd7, 1'b1, 12'hABC));
        check_out("halt_wr", 12'h000, 1'b0, 1'b0, 1'b1, 5'd6);
        start_at(5'd6);
        check_out("new_w6", 12'hABC, 1'b1, 1'b1, 1'b0, 5'd6);
        step();
        check_out("new_halt", 12'h000, 1'b0, 1'b0, 1'b1, 5'd6);

        // Conditional branches: taken with unselected status bits X,
        // not taken with every other bit set
        wr(5'd10, uw(5'd0, 3'd7, 1'b0, 12'h00A));
        wr(5'd1,  uw(5'd0, 3'd7, 1'b0, 12'h001));
        for (int i = 0; i < 6; i++) begin
            wr(5'd0, uw(5'd10, 3'(conds[i]), 1'b0, 12'h0AA));
            start_at(5'd0);
            check($sformatf("br%0d_entry", conds[i]), 32'(CONTROL_BITS), 32'h0AA);
            STATUS_BITS = 5'bxxxxx;
            STATUS_BITS[bits[i]] = 1'b1;
            step();
            check($sformatf("br%0d_taken_upc", conds[i]), 32'(UPC), 32'd10);
            check($sformatf("br%0d_taken_ctrl", conds[i]), 32'(CONTROL_BITS), 32'h00A);
            step();
            check($sformatf("br%0d_taken_done", conds[i]), 32'(DONE), 32'd1);
            if (conds[i] != 1) begin
                STATUS_BITS = 5'b11111;
                STATUS_BITS[bits[i]] = 1'b0;
                start_at(5'd0);
                step();
                check($sformatf("br%0d_seq_upc", conds[i]), 32'(UPC), 32'd1);
                check($sformatf("br%0d_seq_ctrl", conds[i]), 32'(CONTROL_BITS), 32'h001);
                step();
                check($sformatf("br%0d_seq_done", conds[i]), 32'(DONE), 32'd1);
            end
            STATUS_BITS = '0;
        end

        // Wrap-around 31 -> 0
        wr(5'd31, uw(5'd0, 3'd0, 1'b0, 12'h31F));
        wr(5'd0,  uw(5'd0, 3'd7, 1'b0, 12'h0F0));
        start_at(5'd31);
        check_out("wrap_w31", 12'h31F, 1'b0, 1'b1, 1'b0, 5'd31);
        step();
        check_out("wrap_w0", 12'h0F0, 1'b0, 1'b1, 1'b0, 5'd0);
        step();
        check_out("wrap_halt", 12'h000, 1'b0, 1'b0, 1'b1, 5'd0);

        // Asynchronous reset mid-RUN on a self-looping 0x1FFF word
        wr(5'd2, uw(5'd2, 3'd1, 1'b1, 12'hFFF));
        start_at(5'd2);
        check_out("loop_w2", 12'hFFF, 1'b1, 1'b1, 1'b0, 5'd2);
        step();
        check_out("loop_again", 12'hFFF, 1'b1, 1'b1, 1'b0, 5'd2);
        #2;
        SYSTEM_RST = 1'b1;
        #1;
        check_out("async_rst", 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        SYSTEM_RST = 1'b0;
        step();
        check_out("post_rst", 12'h000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Store contents survive reset
        start_at(5'd4);
        check_out("keep_w4", 12'h123, 1'b1, 1'b1, 1'b0, 5'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
